// File: rtl/hero_bus_arb.sv
// Round-robin arbiter for the shared hero write bus: locks the bus to one
// requester per burst, caps burst length and re-emits beats through one register stage.
//
// state    | meaning
// ST_ARB   | no burst open; next accepted beat picks a winner round-robin
// ST_BURST | bus locked to owner until its last beat or the length cap
module hero_bus_arb #(
  parameter int NUM_REQ   = 4,
  parameter int WR_W      = 64,
  parameter int SRC_W     = 2,
  parameter int MAX_BURST = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_vld,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*WR_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]        req_rdy,
  output logic [1:0]                out_cyc,
  output logic [WR_W-1:0]           out_data,
  output logic [SRC_W-1:0]          out_src,
  input  logic                      out_rdy,
  output logic                      busy,
  output logic                      burst_err,
  input  logic                      err_clr
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST);

  localparam logic [1:0] CYC_IDLE  = 2'd0;
  localparam logic [1:0] CYC_VALID = 2'd1;
  localparam logic [1:0] CYC_DONE  = 2'd2;

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(MAX_BURST - 1);

  typedef enum logic {ST_ARB, ST_BURST} state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr, rr_nxt;
  logic [PTR_W-1:0]   owner, owner_nxt;
  logic [CNT_W-1:0]   beat_cnt, cnt_nxt;

  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   scan_idx;

  logic               slot_free;
  logic               gnt_vld;
  logic [PTR_W-1:0]   gnt_idx;
  logic               accept;
  logic               force_end;
  logic               beat_done;
  logic [WR_W-1:0]    gnt_data;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  // first valid requester at or after rr_ptr, with wrap
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && req_vld[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
      scan_idx = ptr_inc(scan_idx);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_ARB;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_nxt;
      owner    <= owner_nxt;
      beat_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    owner_nxt = owner;
    cnt_nxt   = beat_cnt;
    case (state)
      ST_ARB: begin
        if (accept) begin
          rr_nxt = ptr_inc(win_idx);
          if (!req_last[win_idx]) begin
            state_nxt = ST_BURST;
            owner_nxt = win_idx;
            cnt_nxt   = CNT_W'(1);
          end
        end
      end
      ST_BURST: begin
        if (accept) begin
          if (beat_done) begin
            state_nxt = ST_ARB;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = beat_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = ST_ARB;
    endcase
  end

  // rst_n gates acceptance so req_rdy stays low while reset is held
  always_comb begin
    slot_free = (out_cyc == CYC_IDLE) || out_rdy;
    gnt_idx   = (state == ST_BURST) ? owner : win_idx;
    gnt_vld   = (state == ST_BURST) ? req_vld[owner] : win_found;
    accept    = rst_n && slot_free && gnt_vld;
    force_end = (state == ST_BURST) && (beat_cnt == CNT_TC) && !req_last[gnt_idx];
    beat_done = req_last[gnt_idx] || force_end;
    req_rdy   = '0;
    if (accept) req_rdy[gnt_idx] = 1'b1;
    gnt_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == PTR_W'(i)) gnt_data = req_data[i*WR_W +: WR_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cyc  <= CYC_IDLE;
      out_data <= '0;
      out_src  <= '0;
    end else if (accept) begin
      out_cyc  <= beat_done ? CYC_DONE : CYC_VALID;
      out_data <= gnt_data;
      out_src  <= SRC_W'(gnt_idx);
    end else if (out_rdy) begin
      out_cyc  <= CYC_IDLE;
    end
  end

  // a new overflow outranks a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_err <= 1'b0;
    end else if (accept && force_end) begin
      burst_err <= 1'b1;
    end else if (err_clr) begin
      burst_err <= 1'b0;
    end
  end

  assign busy = (state == ST_BURST);

endmodule

// File: tb/tb_hero_bus_arb.sv
// Directed bench for hero_bus_arb: table of per-cycle vectors with hand-computed
// grants and output tags, plus a hand-written reset-mid-burst sequence.
module tb_hero_bus_arb;

  localparam int NUM_REQ   = 4;
  localparam int WR_W      = 64;
  localparam int SRC_W     = 2;
  localparam int MAX_BURST = 16;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] VALID = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NUM_REQ-1:0]      req_vld;
  logic [NUM_REQ-1:0]      req_last;
  logic [NUM_REQ*WR_W-1:0] req_data;
  logic [NUM_REQ-1:0]      req_rdy;
  logic [1:0]              out_cyc;
  logic [WR_W-1:0]         out_data;
  logic [SRC_W-1:0]        out_src;
  logic                    out_rdy;
  logic                    busy;
  logic                    burst_err;
  logic                    err_clr;

  hero_bus_arb #(
    .NUM_REQ(NUM_REQ), .WR_W(WR_W), .SRC_W(SRC_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_last(req_last), .req_data(req_data), .req_rdy(req_rdy),
    .out_cyc(out_cyc), .out_data(out_data), .out_src(out_src), .out_rdy(out_rdy),
    .busy(busy), .burst_err(burst_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] vld;
    logic [3:0] last;
    logic       ordy;
    logic       clr;
    logic [3:0] rdy;
    logic [1:0] cyc;
    logic       busy;
    logic       err;
  } vec_t;

  vec_t            vecs[$];
  int              n_checks = 0;
  int              n_fail   = 0;
  int              sent[NUM_REQ];
  logic [WR_W-1:0] exp_data = '0;
  logic [SRC_W-1:0] exp_src = '0;

  function automatic vec_t mk(input logic [3:0] vld, input logic [3:0] last,
                              input logic ordy, input logic clr, input logic [3:0] rdy,
                              input logic [1:0] cyc, input logic bsy, input logic err);
    vec_t v;
    v.vld = vld; v.last = last; v.ordy = ordy; v.clr = clr;
    v.rdy = rdy; v.cyc = cyc; v.busy = bsy; v.err = err;
    return v;
  endfunction

  // payload encodes requester and its beat number so drops/duplicates show up
  function automatic logic [WR_W-1:0] pay(input int src, input int beat);
    return {16'hBEEF, 8'(src), 8'(beat), 32'(beat * 7 + src)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int idx;
    @(negedge clk);
    req_vld  = v.vld;
    req_last = v.last;
    out_rdy  = v.ordy;
    err_clr  = v.clr;
    for (int i = 0; i < NUM_REQ; i++) req_data[i*WR_W +: WR_W] = pay(i, sent[i]);
    #1;
    chk($sformatf("v%0d_req_rdy", n), 64'(req_rdy), 64'(v.rdy));
    if (v.rdy != 4'b0000) begin
      idx = 0;
      for (int i = 0; i < NUM_REQ; i++) if (v.rdy[i]) idx = i;
      exp_data = pay(idx, sent[idx]);
      exp_src  = SRC_W'(idx);
      sent[idx]++;
    end
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_out_cyc", n), 64'(out_cyc), 64'(v.cyc));
    chk($sformatf("v%0d_out_src", n), 64'(out_src), 64'(exp_src));
    chk($sformatf("v%0d_out_data", n), 64'(out_data), 64'(exp_data));
    chk($sformatf("v%0d_busy", n), 64'(busy), 64'(v.busy));
    chk($sformatf("v%0d_burst_err", n), 64'(burst_err), 64'(v.err));
  endtask

  initial begin
    req_vld  = '1;
    req_last = '0;
    req_data = '0;
    out_rdy  = 1'b1;
    err_clr  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) sent[i] = 0;

    #12;
    chk("rst_req_rdy", 64'(req_rdy), 64'(0));
    chk("rst_out_cyc", 64'(out_cyc), 64'(IDLE));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_src", 64'(out_src), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_burst_err", 64'(burst_err), 64'(0));
    @(negedge clk);
    rst_n   = 1'b1;
    req_vld = '0;

    // idle
    for (int k = 0; k < 10; k++) vecs.push_back(mk(4'b0000, 4'b0000, 1, 0, 4'b0000, IDLE, 0, 0));
    // round robin of single-beat packets
    for (int k = 0; k < 6; k++)
      vecs.push_back(mk(4'b1111, 4'b1111, 1, 0, 4'(1 << (k % 4)), DONE, 0, 0));
    vecs.push_back(mk(4'b0000, 4'b0000, 1, 0, 4'b0000, IDLE, 0, 0));
    // burst lock: req0 3 beats while req1 waits
    vecs.push_back(mk(4'b0011, 4'b0000, 1, 0, 4'b0001, VALID, 1, 0));
    vecs.push_back(mk(4'b0011, 4'b0000, 1, 0, 4'b0001, VALID, 1, 0));
    vecs.push_back(mk(4'b0011, 4'b0001, 1, 0, 4'b0001, DONE, 0, 0));
    vecs.push_back(mk(4'b0010, 4'b0010, 1, 0, 4'b0010, DONE, 0, 0));
    vecs.push_back(mk(4'b0000, 4'b0000, 1, 0, 4'b0000, IDLE, 0, 0));
    // backpressure mid-burst, then owner gap
    vecs.push_back(mk(4'b1000, 4'b0000, 1, 0, 4'b1000, VALID, 1, 0));
    for (int k = 0; k < 5; k++) vecs.push_back(mk(4'b1001, 4'b0000, 0, 0, 4'b0000, VALID, 1, 0));
    vecs.push_back(mk(4'b1000, 4'b0000, 1, 0, 4'b1000, VALID, 1, 0));
    vecs.push_back(mk(4'b0001, 4'b0000, 1, 0, 4'b0000, IDLE, 1, 0));
    vecs.push_back(mk(4'b1000, 4'b0000, 1, 0, 4'b1000, VALID, 1, 0));
    vecs.push_back(mk(4'b1000, 4'b1000, 1, 0, 4'b1000, DONE, 0, 0));
    vecs.push_back(mk(4'b0000, 4'b0000, 1, 0, 4'b0000, IDLE, 0, 0));
    // overlong 20-beat burst from req2
    for (int b = 1; b <= 20; b++)
      vecs.push_back(mk(4'b0100, (b == 20) ? 4'b0100 : 4'b0000, 1, 0, 4'b0100,
                        (b == 16 || b == 20) ? DONE : VALID, !(b == 16 || b == 20), b >= 16));
    vecs.push_back(mk(4'b0000, 4'b0000, 1, 1, 4'b0000, IDLE, 0, 0));
    // overflow coinciding with err_clr keeps the error
    for (int b = 1; b <= 16; b++)
      vecs.push_back(mk(4'b0010, 4'b0000, 1, b == 16, 4'b0010,
                        (b == 16) ? DONE : VALID, b != 16, b == 16));
    vecs.push_back(mk(4'b0000, 4'b0000, 1, 1, 4'b0000, IDLE, 0, 0));
    // first beat of a burst that reset will cut
    vecs.push_back(mk(4'b0100, 4'b0000, 1, 0, 4'b0100, VALID, 1, 0));

    for (int n = 0; n < vecs.size(); n++) run_vec(vecs[n], n);

    // reset during beat 2
    @(negedge clk);
    req_vld  = 4'b0100;
    req_last = 4'b0000;
    out_rdy  = 1'b1;
    err_clr  = 1'b0;
    rst_n    = 1'b0;
    #1;
    exp_data = '0;
    exp_src  = '0;
    chk("mid_rst_req_rdy", 64'(req_rdy), 64'(0));
    chk("mid_rst_out_cyc", 64'(out_cyc), 64'(IDLE));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_out_data", 64'(out_data), 64'(0));
    @(posedge clk);
    #1;
    chk("mid_rst_hold_cyc", 64'(out_cyc), 64'(IDLE));
    chk("mid_rst_hold_busy", 64'(busy), 64'(0));
    @(negedge clk);
    rst_n   = 1'b1;
    req_vld = '0;
    run_vec(mk(4'b1111, 4'b1111, 1, 0, 4'b0001, DONE, 0, 0), 1000);
    run_vec(mk(4'b0000, 4'b0000, 1, 0, 4'b0000, IDLE, 0, 0), 1001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hero_bus_arb.md
Name: hero_bus_arb

Overview:
- Round-robin arbiter sharing one hero write bus among NUM_REQ requesters.
- Each requester presents hero_write beats with a valid/ready handshake; the arbiter locks the bus to one requester for a whole burst.
- Each accepted beat is re-emitted on one registered output stage, tagged with hero::CYCLE_TYPE (IDLE/VALID/DONE) and the source index.
- Sits between the hero write masters and the hero bus slave logic; enforces a maximum burst length.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- WR_W, 64, width of one packed hero_write beat.
- SRC_W, 2, width of source index; must be ≥ ceil(log2(NUM_REQ)).
- MAX_BURST, 16, maximum beats per burst (≥2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_vld  in  NUM_REQ  per-requester beat valid.
- req_last  in  NUM_REQ  per-requester final-beat flag, qualified by req_vld.
- req_data  in  NUM_REQ*WR_W  per-requester beat; requester i occupies bits [i*WR_W +: WR_W].
- req_rdy  out  NUM_REQ  per-requester beat accepted this cycle.
- out_cyc  out  2  hero::CYCLE_TYPE: IDLE=0, VALID=1, DONE=2.
- out_data  out  WR_W  beat payload.
- out_src  out  SRC_W  index of the requester that issued the beat.
- out_rdy  in  1  downstream accepts the current non-IDLE beat.
- busy  out  1  high in BURST state.
- burst_err  out  1  sticky; set when a burst was force-terminated.
- err_clr  in  1  clears burst_err.

Behaviour:
- Reset (async assert, sync release): state=ARB, rr_ptr=0, beat_cnt=0, out_cyc=IDLE, out_data=0, out_src=0, busy=0, burst_err=0. req_rdy is combinational and therefore 0 under reset.
- Output slot free = (out_cyc==IDLE) or out_rdy. No beat is accepted when the slot is not free; req_rdy stays all 0.
- At most one req_rdy bit is high per cycle; req_rdy[i] implies req_vld[i]. Accepting a beat is combinational (req_rdy in the same cycle as req_vld).
- Accepted beat appears on out_* the next cycle. Latency is 1.
- out_cyc is VALID for a non-final beat. It is DONE when req_last=1 or when the beat is force-terminated.
- While out_cyc != IDLE and out_rdy=0, out_cyc, out_data and out_src hold stable.
- If out_rdy=1 and no beat is accepted, out_cyc becomes IDLE next cycle. out_data and out_src then hold their previous values.
- State ARB:
  - Winner is the first requester with req_vld set, scanning from rr_ptr upward with wrap.
  - If the slot is free and a winner exists, assert req_rdy[winner] and set rr_ptr = winner+1 mod NUM_REQ.
  - If the beat is last, stay in ARB. Otherwise go to BURST with owner=winner and beat_cnt=1.
- State BURST:
  - Only req_rdy[owner] can be asserted; other requesters are ignored.
  - On each accepted beat, beat_cnt increments.
  - If the beat has req_last=1, emit DONE and go to ARB.
  - Else if this is beat MAX_BURST (beat_cnt==MAX_BURST-1 before increment), emit DONE, set burst_err and go to ARB.
  - The owner's remaining beats then re-arbitrate as a new burst.
  - beat_cnt resets to 0 on entry to ARB.
  - An owner dropping req_vld mid-burst stalls the burst indefinitely; the bus stays locked.
- A single-beat burst (req_last on the first beat) never enters BURST.
- busy = (state==BURST).
- burst_err: if set and clear occur in the same cycle, set wins. Otherwise err_clr clears it.
- rr_ptr advances only on the first beat of a burst; it wraps from NUM_REQ-1 to 0.
- Asserting reset mid-burst drops the burst immediately; the bus returns to the reset state with no DONE emitted.

Test Plan:
- Reset then idle: all req_vld=0, out_rdy=1 for 10 cycles -> out_cyc=IDLE throughout, req_rdy=0, busy=0.
- Round-robin: all 4 requesters present single-beat last packets continuously, out_rdy=1 -> out_src sequence 0,1,2,3,0,1; every out_cyc=DONE; one beat per cycle.
- Burst lock: req0 sends a 3-beat burst while req1 is valid throughout -> out shows src0 VALID, VALID, DONE, then src1. req_rdy[1]=0 during req0's burst; busy high for 2 cycles.
- Backpressure: out_rdy=0 for 5 cycles mid-burst -> out_* frozen, req_rdy all 0. After release the burst resumes with no beat lost or duplicated; the scoreboard compares payloads.
- Overlong burst: MAX_BURST=16, req2 sends 20 beats with last on beat 20.
  - Beat 16 is DONE and burst_err=1.
  - Beats 17-20 form a new burst: VALID×3, then DONE.
  - err_clr pulse later clears burst_err; err_clr in the same cycle as a new overflow leaves burst_err=1.
- Reset mid-burst: rst_n low during beat 2 of 4 -> out_cyc=IDLE, busy=0, rr_ptr=0 immediately. After release, req0 wins first.
